// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the 4-bit-opcode CPU: opcodes, ALU operation
// codes and the per-stage control bundle.
package cpu_ctrl_pkg;

  localparam int REG_AW_MAX = 4;

  typedef enum logic [3:0] {
    OP_LB   = 4'd0,
    OP_LHB  = 4'd1,
    OP_JMP  = 4'd2,
    OP_STR  = 4'd3,
    OP_LIM  = 4'd4,
    OP_MVB  = 4'd5,
    OP_MVF  = 4'd6,
    OP_ADD  = 4'd7,
    OP_SUB  = 4'd8,
    OP_SFT  = 4'd9,
    OP_BNE  = 4'd10,
    OP_BEQ  = 4'd11,
    OP_BLT  = 4'd12,
    OP_INC  = 4'd13,
    OP_HALT = 4'd14,
    OP_BLS  = 4'd15
  } opcode_e;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SFL = 4'd2;
  localparam logic [3:0] ALU_SFR = 4'd3;
  localparam logic [3:0] ALU_INC = 4'd4;
  localparam logic [3:0] ALU_DEC = 4'd5;
  localparam logic [3:0] ALU_BNE = 4'd6;
  localparam logic [3:0] ALU_BEQ = 4'd7;
  localparam logic [3:0] ALU_BLT = 4'd8;
  localparam logic [3:0] ALU_LHB = 4'd9;
  localparam logic [3:0] ALU_JMP = 4'd10;
  localparam logic [3:0] ALU_BLS = 4'd11;

  // dst is sized for the widest register file; narrower units truncate.
  typedef struct packed {
    logic                  valid;
    logic [3:0]            alu_inst;
    logic                  write_reg;
    logic                  read_mem;
    logic                  write_mem;
    logic                  is_branch;
    logic                  is_halt;
    logic [REG_AW_MAX-1:0] dst;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder producing a control bundle; shared between the
// pipelined and single-cycle cores.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic                  valid_i,
  input  logic [3:0]            opcode_i,
  input  logic                  imm_flag_i,
  input  logic [REG_AW_MAX-1:0] dst_i,
  output ctrl_bundle_t          bundle_o
);

  always_comb begin
    // NOTE: every field gets a default first so no path through the case infers a latch.
    bundle_o       = '0;
    bundle_o.valid = valid_i;
    bundle_o.dst   = dst_i;
    case (opcode_e'(opcode_i))
      OP_ADD: begin bundle_o.alu_inst = ALU_ADD; bundle_o.write_reg = 1'b1; end
      OP_SUB: begin bundle_o.alu_inst = ALU_SUB; bundle_o.write_reg = 1'b1; end
      OP_SFT: begin
        bundle_o.alu_inst  = imm_flag_i ? ALU_SFR : ALU_SFL;
        bundle_o.write_reg = 1'b1;
      end
      OP_INC: begin
        bundle_o.alu_inst  = imm_flag_i ? ALU_DEC : ALU_INC;
        bundle_o.write_reg = 1'b1;
      end
      OP_LHB: begin bundle_o.alu_inst = ALU_LHB; bundle_o.write_reg = 1'b1; end
      OP_LB:  begin bundle_o.write_reg = 1'b1; bundle_o.read_mem = 1'b1; end
      OP_STR: bundle_o.write_mem = 1'b1;
      OP_LIM, OP_MVB, OP_MVF: bundle_o.write_reg = 1'b1;
      OP_BNE: begin bundle_o.alu_inst = ALU_BNE; bundle_o.is_branch = 1'b1; end
      OP_BEQ: begin bundle_o.alu_inst = ALU_BEQ; bundle_o.is_branch = 1'b1; end
      OP_BLT: begin bundle_o.alu_inst = ALU_BLT; bundle_o.is_branch = 1'b1; end
      OP_BLS: begin bundle_o.alu_inst = ALU_BLS; bundle_o.is_branch = 1'b1; end
      OP_JMP: begin bundle_o.alu_inst = ALU_JMP; bundle_o.is_branch = 1'b1; end
      OP_HALT: bundle_o.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes in ID, carries control through EX/MEM/WB,
// and handles load-use stalls, taken-branch flushes and HALT freezing.
module pipe_ctrl_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_AW       = 3,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic              id_imm_flag,
  input  logic [REG_AW-1:0] id_src_a,
  input  logic [REG_AW-1:0] id_src_b,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              ex_branch_taken,
  output logic              stall_if,
  output logic              flush_ifid,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_inst,
  output logic              mem_write_mem,
  output logic              mem_read_mem,
  output logic              wb_write_reg,
  output logic [REG_AW-1:0] wb_dst,
  output logic              halted
);

  localparam logic [1:0] CNT_LOAD = 2'(LOAD_BUBBLES - 1);

  ctrl_bundle_t      id_bundle;
  ctrl_bundle_t      ex_d, ex_q;
  logic              mem_valid_d, mem_valid_q;
  logic              mem_write_reg_d, mem_write_reg_q;
  logic              mem_read_mem_d, mem_read_mem_q;
  logic              mem_write_mem_d, mem_write_mem_q;
  logic              mem_halt_d, mem_halt_q;
  logic [REG_AW-1:0] mem_dst_d, mem_dst_q;
  logic              wb_valid_d, wb_valid_q;
  logic              wb_write_reg_d, wb_write_reg_q;
  logic [REG_AW-1:0] wb_dst_d, wb_dst_q;
  logic [1:0]        cnt_d, cnt_q;
  logic              halt_pending_d, halt_pending_q;
  logic              halted_d, halted_q;
  logic              flush, hazard, stall, src_hit;

  ctrl_decode u_decode (
    .valid_i    (id_valid),
    .opcode_i   (id_opcode),
    .imm_flag_i (id_imm_flag),
    .dst_i      (REG_AW_MAX'(id_dst)),
    .bundle_o   (id_bundle)
  );

  always_comb begin
    flush   = ex_q.valid & ex_q.is_branch & ex_branch_taken;
    // Full-width compare: the load's dst is zero-extended like the sources.
    src_hit = (ex_q.dst == REG_AW_MAX'(id_src_a)) | (ex_q.dst == REG_AW_MAX'(id_src_b));
    hazard  = id_valid & ex_q.valid & ex_q.read_mem & src_hit & ~flush;
    stall   = halt_pending_q | (~flush & (hazard | (cnt_q != 2'd0)));

    cnt_d = cnt_q;
    if (flush)               cnt_d = 2'd0;
    else if (hazard)         cnt_d = CNT_LOAD;
    else if (cnt_q != 2'd0)  cnt_d = cnt_q - 2'd1;

    ex_d = (id_valid && !flush && !stall) ? id_bundle : '0;
    halt_pending_d = halt_pending_q | (ex_d.valid & ex_d.is_halt);

    mem_valid_d     = ex_q.valid;
    mem_write_reg_d = ex_q.valid & ex_q.write_reg;
    mem_read_mem_d  = ex_q.valid & ex_q.read_mem;
    mem_write_mem_d = ex_q.valid & ex_q.write_mem;
    mem_halt_d      = ex_q.valid & ex_q.is_halt;
    mem_dst_d       = ex_q.dst[REG_AW-1:0];

    wb_valid_d     = mem_valid_q;
    wb_write_reg_d = mem_valid_q & mem_write_reg_q;
    wb_dst_d       = mem_dst_q;

    halted_d = halted_q | (mem_valid_q & mem_halt_q);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ex_q            <= '0;
      mem_valid_q     <= 1'b0;
      mem_write_reg_q <= 1'b0;
      mem_read_mem_q  <= 1'b0;
      mem_write_mem_q <= 1'b0;
      mem_halt_q      <= 1'b0;
      mem_dst_q       <= '0;
      wb_valid_q      <= 1'b0;
      wb_write_reg_q  <= 1'b0;
      wb_dst_q        <= '0;
      cnt_q           <= 2'd0;
      halt_pending_q  <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      ex_q            <= ex_d;
      mem_valid_q     <= mem_valid_d;
      mem_write_reg_q <= mem_write_reg_d;
      mem_read_mem_q  <= mem_read_mem_d;
      mem_write_mem_q <= mem_write_mem_d;
      mem_halt_q      <= mem_halt_d;
      mem_dst_q       <= mem_dst_d;
      wb_valid_q      <= wb_valid_d;
      wb_write_reg_q  <= wb_write_reg_d;
      wb_dst_q        <= wb_dst_d;
      cnt_q           <= cnt_d;
      halt_pending_q  <= halt_pending_d;
      halted_q        <= halted_d;
    end
  end

  assign stall_if      = stall;
  assign flush_ifid    = flush;
  assign ex_valid      = ex_q.valid;
  assign ex_alu_inst   = ex_q.alu_inst & {4{ex_q.valid}};
  assign mem_write_mem = mem_valid_q & mem_write_mem_q;
  assign mem_read_mem  = mem_valid_q & mem_read_mem_q;
  assign wb_write_reg  = wb_valid_q & wb_write_reg_q;
  assign wb_dst        = wb_dst_q & {REG_AW{wb_valid_q}};
  assign halted        = halted_q;

endmodule
